// File: rtl/ram_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    localparam int         LANE_WIDTH = 8;
    localparam int         NUM_LANES  = 4;
    localparam logic [3:0] SEL_WORD   = 4'b1111;
    localparam logic [3:0] SEL_NONE   = 4'b0000;

    // Counter preload for the WAIT state; zero wait states never enter WAIT.
    function automatic logic [3:0] waitLoad(input int waitStates);
        return (waitStates > 0) ? 4'(waitStates - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/ram_lane_array.sv
// Word-addressed storage with per-byte-lane write enables and a registered read port.
module ram_lane_array
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_index,
    input  logic [NUM_LANES-1:0]  i_laneWe,
    input  logic [31:0]           i_wrData,
    input  logic                  i_rdEn,
    input  logic                  i_rdZero,
    output logic [31:0]           o_rdData
);

    logic [31:0] r_mem [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0] r_rdData;

    // Storage itself is never reset, so a write at the reset edge only touches enabled lanes.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_laneWe[l]) begin
                r_mem[i_index][l*LANE_WIDTH +: LANE_WIDTH] <= i_wrData[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= i_rdZero ? 32'd0 : r_mem[i_index];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/ram_responder.sv
// Data-memory responder that completes each request after WAIT_STATES idle cycles.
// Define RAM_ERR_EN to add the err port and out-of-range suppression.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabler,
    input  logic        write_enabler,
    input  logic [31:0] addr,
    input  logic [3:0]  select,
    input  logic [31:0] data_input,
    output logic [31:0] data_output,
    output logic        ready
`ifdef RAM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [3:0] WAIT_LOAD = waitLoad(WAIT_STATES);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_waitCnt;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [3:0]            r_sel;
    logic [31:0]           r_wrData;
    logic                  r_write;
    logic                  w_oob;
    logic [NUM_LANES-1:0]  w_laneWe;
    logic                  w_rdEn;
    logic                  w_unusedAddr;

    assign w_unusedAddr = ^{addr[1:0], addr[31:ADDR_WIDTH+2]};

`ifdef RAM_ERR_EN
    logic r_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oob <= 1'b0;
        end else if (r_state == IDLE && enabler) begin
            r_oob <= |addr[31:ADDR_WIDTH+2];
        end
    end

    assign w_oob = r_oob;
    assign err   = (r_state == DONE) && r_oob;
`else
    assign w_oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_waitCnt <= 4'd0;
            r_index   <= '0;
            r_sel     <= SEL_NONE;
            r_wrData  <= '0;
            r_write   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && enabler) begin
                r_waitCnt <= WAIT_LOAD;
                r_index   <= addr[ADDR_WIDTH+1:2];
                r_sel     <= select;
                r_wrData  <= data_input;
                r_write   <= write_enabler;
            end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_laneWe    = SEL_NONE;
        w_rdEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enabler) begin
                    w_nextState = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                w_laneWe    = (r_write && !w_oob) ? r_sel : SEL_NONE;
                w_rdEn      = !r_write;
                w_nextState = DONE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign ready = (r_state == DONE);

    ram_lane_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .i_index (r_index),
        .i_laneWe(w_laneWe),
        .i_wrData(r_wrData),
        .i_rdEn  (w_rdEn),
        .i_rdZero(w_oob),
        .o_rdData(data_output)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with two wait states, one with none.
module tb_ram_responder;

    logic        clk;
    logic        rst;

    logic        enabler;
    logic        writeEnabler;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] dataInput;
    logic [31:0] dataOutput;
    logic        ready;
    logic        err;

    logic        en0;
    logic        we0;
    logic [31:0] addr0;
    logic [3:0]  sel0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        rdy0;
    logic        err0;

    int assertCount;
    int failCount;

    int          cycles;
    logic [31:0] rdData;
    logic        errSeen;

    ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enabler      (enabler),
        .write_enabler(writeEnabler),
        .addr         (addr),
        .select       (select),
        .data_input   (dataInput),
        .data_output  (dataOutput),
        .ready        (ready)
`ifdef RAM_ERR_EN
        ,
        .err          (err)
`endif
    );

    ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .enabler      (en0),
        .write_enabler(we0),
        .addr         (addr0),
        .select       (sel0),
        .data_input   (din0),
        .data_output  (dout0),
        .ready        (rdy0)
`ifdef RAM_ERR_EN
        ,
        .err          (err0)
`endif
    );

`ifndef RAM_ERR_EN
    assign err  = 1'b0;
    assign err0 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction on the two-wait-state instance, starting from an IDLE cycle.
    task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, output int n, output logic [31:0] rd,
                                 output logic e);
        writeEnabler = we;
        addr         = a;
        select       = s;
        dataInput    = d;
        enabler      = 1'b1;
        n            = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 40);
        rd      = dataOutput;
        e       = err;
        enabler = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Same transaction shape on the zero-wait-state instance.
    task automatic applyStimulus0(input logic we, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d, output int n);
        we0   = we;
        addr0 = a;
        sel0  = s;
        din0  = d;
        en0   = 1'b1;
        n     = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy0 && n < 40);
        en0 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        rst          = 1'b0;
        enabler      = 1'b0;
        writeEnabler = 1'b0;
        addr         = '0;
        select       = 4'b0000;
        dataInput    = '0;
        en0          = 1'b0;
        we0          = 1'b0;
        addr0        = '0;
        sel0         = 4'b0000;
        din0         = '0;

        #12;
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_dout", dataOutput, 32'd0);
        checkOutput("reset_ready0", {31'd0, rdy0}, 32'd0);
        checkOutput("reset_dout0", dout0, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, cycles, rdData, errSeen);
        checkOutput("wr10_latency", cycles, 32'd4);
        checkOutput("wr10_err", {31'd0, errSeen}, 32'd0);
        applyStimulus(1'b0, 32'h10, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("rd10_latency", cycles, 32'd4);
        checkOutput("rd10_data", rdData, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h20, 4'b1111, 32'h11223344, cycles, rdData, errSeen);
        applyStimulus(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, cycles, rdData, errSeen);
        checkOutput("dout_hold_wr", rdData, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h20, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("lane_merge", rdData, 32'h11BB33DD);
        applyStimulus(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, cycles, rdData, errSeen);
        checkOutput("sel_none_latency", cycles, 32'd4);
        checkOutput("sel_none_hold", rdData, 32'h11BB33DD);
        applyStimulus(1'b0, 32'h20, 4'b1111, 32'h0, cycles, rdData, errSeen);
        checkOutput("sel_none_word", rdData, 32'h11BB33DD);

        // Held enabler: the data changes once the first request is in DONE.
        writeEnabler = 1'b1;
        addr         = 32'h30;
        select       = 4'b1111;
        dataInput    = 32'h0000AAAA;
        enabler      = 1'b1;
        cycles       = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ready && cycles < 40);
        checkOutput("held_first_latency", cycles, 32'd4);
        dataInput = 32'h0000BBBB;
        cycles    = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) checkOutput("held_no_repeat", {31'd0, ready}, 32'd0);
        end while (!ready && cycles < 40);
        checkOutput("held_second_gap", cycles, 32'd5);
        enabler = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h30, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("held_word", rdData, 32'h0000BBBB);

        // Asynchronous reset while a read sits in DONE.
        writeEnabler = 1'b0;
        addr         = 32'h20;
        enabler      = 1'b1;
        cycles       = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ready && cycles < 40);
        checkOutput("pre_reset_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("async_reset_dout", dataOutput, 32'd0);
        enabler = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h10, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("post_reset_latency", cycles, 32'd4);
        checkOutput("post_reset_data", rdData, 32'hDEADBEEF);

        // Upper address bits: aliasing by default, suppressed with the error option.
        applyStimulus(1'b1, 32'h0, 4'b1111, 32'h0BADF00D, cycles, rdData, errSeen);
        applyStimulus(1'b1, 32'h00001000, 4'b1111, 32'hCAFEF00D, cycles, rdData, errSeen);
        checkOutput("oob_latency", cycles, 32'd4);
`ifdef RAM_ERR_EN
        checkOutput("oob_err", {31'd0, errSeen}, 32'd1);
        applyStimulus(1'b0, 32'h0, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("oob_word0", rdData, 32'h0BADF00D);
        applyStimulus(1'b0, 32'h00001000, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("oob_rd_zero", rdData, 32'h0);
`else
        applyStimulus(1'b0, 32'h0, 4'b0000, 32'h0, cycles, rdData, errSeen);
        checkOutput("alias_word0", rdData, 32'hCAFEF00D);
`endif

        // Zero wait states: back-to-back reads with the enabler held.
        applyStimulus0(1'b1, 32'h0, 4'b1111, 32'h01234567, cycles);
        checkOutput("ws0_wr_latency", cycles, 32'd2);
        applyStimulus0(1'b1, 32'h4, 4'b1111, 32'h89ABCDEF, cycles);
        we0   = 1'b0;
        addr0 = 32'h0;
        en0   = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy0 && cycles < 40);
        checkOutput("ws0_rd0_latency", cycles, 32'd2);
        checkOutput("ws0_rd0_data", dout0, 32'h01234567);
        addr0  = 32'h4;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy0 && cycles < 40);
        checkOutput("ws0_ready_spacing", cycles, 32'd3);
        checkOutput("ws0_rd4_data", dout0, 32'h89ABCDEF);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ws0_idle_ready", {31'd0, rdy0}, 32'd0);
        checkOutput("ws0_err_idle", {31'd0, err0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
